lsu_dmem_resp: RTL and testbench

//  Data-memory responder serving the two LSU slots of a VLIW bundle. Accepts byte-addressed

---
 rtl/lsu_dmem_resp.sv | 151 +++++++++++++++
 tb/tb_lsu_dmem_resp.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_resp.sv
// Dual-slot data memory for the VLIW LSU pair: 2R2W word array with byte lanes,
// write-first forwarding between same-cycle stores and loads, and registered load responses.
module lsu_dmem_resp #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        p0_wr_en,
  input  logic [31:0] p0_wr_addr,
  input  logic [31:0] p0_wr_data,
  input  logic [1:0]  p0_wr_size,
  input  logic        p0_rd_en,
  input  logic [31:0] p0_rd_addr,
  output logic [31:0] p0_rd_data,
  output logic        p0_rd_valid,
  output logic        p0_err,
  input  logic        p1_wr_en,
  input  logic [31:0] p1_wr_addr,
  input  logic [31:0] p1_wr_data,
  input  logic [1:0]  p1_wr_size,
  input  logic        p1_rd_en,
  input  logic [31:0] p1_rd_addr,
  output logic [31:0] p1_rd_data,
  output logic        p1_rd_valid,
  output logic        p1_err
);

  logic [31:0]           r_mem [DEPTH_WORDS];
  logic [1:0][31:0]      r_rd_data;
  logic [1:0]            r_rd_valid;
  logic [1:0]            r_err;

  logic [1:0]            w_wr_en;
  logic [1:0]            w_rd_en;
  logic [1:0][31:0]      w_wr_addr;
  logic [1:0][31:0]      w_wr_data;
  logic [1:0][1:0]       w_wr_size;
  logic [1:0][31:0]      w_rd_addr;
  logic [1:0]            w_wr_ok;
  logic [1:0]            w_rd_inrange;
  logic [1:0][IDX_W-1:0] w_wr_idx;
  logic [1:0][IDX_W-1:0] w_rd_idx;
  logic [1:0][3:0]       w_wr_be;
  logic [1:0][31:0]      w_wr_lane;
  logic [1:0][31:0]      w_rd_merged;
  logic [1:0][31:0]      w_rd_shifted;
  logic                  w_wr_allow;

  assign w_wr_en   = {p1_wr_en, p0_wr_en};
  assign w_rd_en   = {p1_rd_en, p0_rd_en};
  assign w_wr_addr = {p1_wr_addr, p0_wr_addr};
  assign w_wr_data = {p1_wr_data, p0_wr_data};
  assign w_wr_size = {p1_wr_size, p0_wr_size};
  assign w_rd_addr = {p1_rd_addr, p0_rd_addr};

  // A reset held across the edge must also discard the store presented in that cycle.
  assign w_wr_allow = ~stall & ~rst;

  function automatic logic f_aligned(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'b00:   f_aligned = 1'b1;
      2'b01:   f_aligned = ~ofs[0];
      2'b10:   f_aligned = (ofs == 2'b00);
      default: f_aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'b00:   f_byte_en = 4'b0001 << ofs;
      2'b01:   f_byte_en = 4'b0011 << ofs;
      2'b10:   f_byte_en = 4'b1111;
      default: f_byte_en = 4'b0000;
    endcase
  endfunction

  always_comb begin
    w_wr_ok      = '0;
    w_rd_inrange = '0;
    w_wr_idx     = '0;
    w_rd_idx     = '0;
    w_wr_be      = '0;
    w_wr_lane    = '0;
    for (int s = 0; s < 2; s++) begin
      w_wr_idx[s]     = w_wr_addr[s][IDX_W+1:2];
      w_rd_idx[s]     = w_rd_addr[s][IDX_W+1:2];
      w_rd_inrange[s] = (w_rd_addr[s][31:IDX_W+2] == '0);
      w_wr_ok[s]      = (w_wr_addr[s][31:IDX_W+2] == '0) &&
                        f_aligned(w_wr_size[s], w_wr_addr[s][1:0]);
      w_wr_lane[s]    = w_wr_data[s] << {w_wr_addr[s][1:0], 3'b000};
      if (w_wr_en[s] && w_wr_ok[s]) begin
        w_wr_be[s] = f_byte_en(w_wr_size[s], w_wr_addr[s][1:0]);
      end
    end
  end

  // Write-first: overlay this cycle's legal store bytes, p1 last so it wins overlaps.
  always_comb begin
    w_rd_merged  = '0;
    w_rd_shifted = '0;
    for (int r = 0; r < 2; r++) begin
      w_rd_merged[r] = r_mem[w_rd_idx[r]];
      for (int s = 0; s < 2; s++) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wr_be[s][b] && (w_wr_idx[s] == w_rd_idx[r])) begin
            w_rd_merged[r][8*b +: 8] = w_wr_lane[s][8*b +: 8];
          end
        end
      end
      w_rd_shifted[r] = w_rd_merged[r] >> {w_rd_addr[r][1:0], 3'b000};
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_allow) begin
      for (int s = 0; s < 2; s++) begin
        for (int b = 0; b < 4; b++) begin
          if (w_wr_be[s][b]) begin
            r_mem[w_wr_idx[s]][8*b +: 8] <= w_wr_lane[s][8*b +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= '0;
      r_err      <= '0;
    end else if (!stall) begin
      for (int s = 0; s < 2; s++) begin
        r_rd_valid[s] <= w_rd_en[s];
        r_err[s]      <= (w_wr_en[s] & ~w_wr_ok[s]) | (w_rd_en[s] & ~w_rd_inrange[s]);
        if (w_rd_en[s]) begin
          r_rd_data[s] <= w_rd_inrange[s] ? w_rd_shifted[s] : 32'h0;
        end
      end
    end
  end

  assign p0_rd_data  = r_rd_data[0];
  assign p1_rd_data  = r_rd_data[1];
  assign p0_rd_valid = r_rd_valid[0];
  assign p1_rd_valid = r_rd_valid[1];
  assign p0_err      = r_err[0];
  assign p1_err      = r_err[1];

endmodule

// File: tb/tb_lsu_dmem_resp.sv
// Scoreboard bench for lsu_dmem_resp: a byte-array reference model predicts each cycle's
// response when the stimulus is driven; each scenario task pops and compares it.
module tb_lsu_dmem_resp;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic        p0_wr_en, p0_rd_en, p1_wr_en, p1_rd_en;
  logic [31:0] p0_wr_addr, p0_wr_data, p0_rd_addr, p1_wr_addr, p1_wr_data, p1_rd_addr;
  logic [1:0]  p0_wr_size, p1_wr_size;
  logic [31:0] p0_rd_data, p1_rd_data;
  logic        p0_rd_valid, p1_rd_valid, p0_err, p1_err;

  lsu_dmem_resp #(.DEPTH_WORDS(1024), .IDX_W(10)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .p0_wr_en(p0_wr_en), .p0_wr_addr(p0_wr_addr), .p0_wr_data(p0_wr_data), .p0_wr_size(p0_wr_size),
    .p0_rd_en(p0_rd_en), .p0_rd_addr(p0_rd_addr), .p0_rd_data(p0_rd_data),
    .p0_rd_valid(p0_rd_valid), .p0_err(p0_err),
    .p1_wr_en(p1_wr_en), .p1_wr_addr(p1_wr_addr), .p1_wr_data(p1_wr_data), .p1_wr_size(p1_wr_size),
    .p1_rd_en(p1_rd_en), .p1_rd_addr(p1_rd_addr), .p1_rd_data(p1_rd_data),
    .p1_rd_valid(p1_rd_valid), .p1_err(p1_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0][31:0] d;
    logic [1:0]       v;
    logic [1:0]       e;
  } exp_t;

  exp_t             sbq [$];
  exp_t             exp_r;
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [7:0]       mb [0:4095];
  logic [1:0][31:0] mod_d;
  logic [1:0]       mod_v;
  logic [1:0]       mod_err;
  logic [1:0][31:0] act_d;
  logic [1:0]       act_v;
  logic [1:0]       act_e;

  assign act_d = {p1_rd_data, p0_rd_data};
  assign act_v = {p1_rd_valid, p0_rd_valid};
  assign act_e = {p1_err, p0_err};

  task automatic clear_inputs();
    stall = 1'b0;
    p0_wr_en = 1'b0; p0_wr_addr = '0; p0_wr_data = '0; p0_wr_size = '0;
    p0_rd_en = 1'b0; p0_rd_addr = '0;
    p1_wr_en = 1'b0; p1_wr_addr = '0; p1_wr_data = '0; p1_wr_size = '0;
    p1_rd_en = 1'b0; p1_rd_addr = '0;
  endtask

  task automatic st(input int s, input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    if (s == 0) begin
      p0_wr_en = 1'b1; p0_wr_addr = a; p0_wr_data = d; p0_wr_size = sz;
    end else begin
      p1_wr_en = 1'b1; p1_wr_addr = a; p1_wr_data = d; p1_wr_size = sz;
    end
  endtask

  task automatic ld(input int s, input logic [31:0] a);
    if (s == 0) begin
      p0_rd_en = 1'b1; p0_rd_addr = a;
    end else begin
      p1_rd_en = 1'b1; p1_rd_addr = a;
    end
  endtask

  function automatic logic [31:0] load_word(input logic [31:0] a);
    logic [11:0] w;
    logic [31:0] word;
    w    = {a[11:2], 2'b00};
    word = {mb[w + 12'd3], mb[w + 12'd2], mb[w + 12'd1], mb[w]};
    return word >> (8 * int'(a[1:0]));
  endfunction

  // Reference model: stores land in the byte array first, so same-cycle loads see them.
  task automatic step();
    logic [1:0]       we, re;
    logic [1:0][31:0] wa, wd, ra;
    logic [1:0][1:0]  ws;
    exp_t             e;
    we = {p1_wr_en, p0_wr_en};     re = {p1_rd_en, p0_rd_en};
    wa = {p1_wr_addr, p0_wr_addr}; wd = {p1_wr_data, p0_wr_data};
    ra = {p1_rd_addr, p0_rd_addr}; ws = {p1_wr_size, p0_wr_size};
    if (!stall) begin
      for (int s = 0; s < 2; s++) begin
        bit legal;
        int n;
        legal = (wa[s] < 32'd4096) &&
                ((ws[s] == 2'd0) || (ws[s] == 2'd1 && wa[s][0] == 1'b0) ||
                 (ws[s] == 2'd2 && wa[s][1:0] == 2'b00));
        mod_err[s] = (we[s] && !legal) || (re[s] && ra[s] >= 32'd4096);
        n = (ws[s] == 2'd0) ? 1 : (ws[s] == 2'd1) ? 2 : 4;
        if (we[s] && legal) begin
          for (int i = 0; i < n; i++) mb[wa[s][11:0] + 12'(i)] = wd[s][8*i +: 8];
        end
      end
      for (int s = 0; s < 2; s++) begin
        mod_v[s] = re[s];
        if (re[s]) mod_d[s] = (ra[s] < 32'd4096) ? load_word(ra[s]) : 32'h0;
      end
    end
    e.d = mod_d; e.v = mod_v; e.e = mod_err;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #12;
    n_checks++; if (p0_rd_data !== 32'h0 || p1_rd_data !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_rd_data got %h/%h exp 0/0", p0_rd_data, p1_rd_data); end
    n_checks++; if (act_v !== 2'b00) begin
      n_fail++; $display("[TB] FAIL reset_rd_valid got %b exp 00", act_v); end
    n_checks++; if (act_e !== 2'b00) begin
      n_fail++; $display("[TB] FAIL reset_err got %b exp 00", act_e); end
    rst = 1'b0;
    mod_d = '0; mod_v = '0; mod_err = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_store_load();
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      case (k)
        0: st(0, 32'h10, 32'hDEADBEEF, 2'b10);
        1: ld(0, 32'h10);
        2: st(0, 32'h10, 32'h11223344, 2'b10);
        3: st(0, 32'h13, 32'h000000AA, 2'b00);
        4: begin ld(0, 32'h10); ld(1, 32'h13); end
        default: ;
      endcase
      step();
      exp_r = sbq.pop_front();
      for (int s = 0; s < 2; s++) begin
        n_checks++; if (act_v[s] !== exp_r.v[s]) begin
          n_fail++; $display("[TB] FAIL store_load k%0d p%0d rd_valid got %b exp %b", k, s, act_v[s], exp_r.v[s]); end
        n_checks++; if (act_d[s] !== exp_r.d[s]) begin
          n_fail++; $display("[TB] FAIL store_load k%0d p%0d rd_data got %h exp %h", k, s, act_d[s], exp_r.d[s]); end
        n_checks++; if (act_e[s] !== exp_r.e[s]) begin
          n_fail++; $display("[TB] FAIL store_load k%0d p%0d err got %b exp %b", k, s, act_e[s], exp_r.e[s]); end
      end
      if (k == 1) begin
        n_checks++; if (p0_rd_data !== 32'hDEADBEEF || p0_rd_valid !== 1'b1) begin
          n_fail++; $display("[TB] FAIL word_load got %h/%b exp deadbeef/1", p0_rd_data, p0_rd_valid); end
      end
      if (k == 4) begin
        n_checks++; if (p0_rd_data !== 32'hAA223344 || p1_rd_data[7:0] !== 8'hAA) begin
          n_fail++; $display("[TB] FAIL byte_store got %h/%h exp aa223344/aa", p0_rd_data, p1_rd_data[7:0]); end
      end
    end
  endtask

  task automatic test_merge();
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      case (k)
        0: begin st(0, 32'h20, 32'h11111111, 2'b10); st(1, 32'h22, 32'h0000BEEF, 2'b01);
                 ld(0, 32'h20); ld(1, 32'h22); end
        1: begin st(0, 32'h24, 32'hAAAAAAAA, 2'b10); st(1, 32'h25, 32'h00000077, 2'b00);
                 ld(1, 32'h24); end
        2: begin st(0, 32'h28, 32'h12345678, 2'b10); st(1, 32'h28, 32'hCAFEF00D, 2'b10);
                 ld(0, 32'h28); end
        3: begin ld(0, 32'h24); ld(1, 32'h28); end
        4: begin st(0, 32'h2C, 32'h01020304, 2'b10); st(1, 32'h40, 32'h0A0B0C0D, 2'b10); end
        default: begin ld(0, 32'h2E); ld(1, 32'h40); end
      endcase
      step();
      exp_r = sbq.pop_front();
      for (int s = 0; s < 2; s++) begin
        n_checks++; if (act_v[s] !== exp_r.v[s]) begin
          n_fail++; $display("[TB] FAIL merge k%0d p%0d rd_valid got %b exp %b", k, s, act_v[s], exp_r.v[s]); end
        n_checks++; if (act_d[s] !== exp_r.d[s]) begin
          n_fail++; $display("[TB] FAIL merge k%0d p%0d rd_data got %h exp %h", k, s, act_d[s], exp_r.d[s]); end
        n_checks++; if (act_e[s] !== exp_r.e[s]) begin
          n_fail++; $display("[TB] FAIL merge k%0d p%0d err got %b exp %b", k, s, act_e[s], exp_r.e[s]); end
      end
      if (k == 0) begin
        n_checks++; if (p0_rd_data !== 32'hBEEF1111 || p1_rd_data !== 32'h0000BEEF) begin
          n_fail++; $display("[TB] FAIL write_first got %h/%h exp beef1111/0000beef", p0_rd_data, p1_rd_data); end
      end
      if (k == 2) begin
        n_checks++; if (p0_rd_data !== 32'hCAFEF00D) begin
          n_fail++; $display("[TB] FAIL p1_wins got %h exp cafef00d", p0_rd_data); end
      end
    end
  endtask

  task automatic test_errors();
    for (int k = 0; k < 8; k++) begin
      clear_inputs();
      case (k)
        0: st(0, 32'h30, 32'h0BADF00D, 2'b10);
        1: st(0, 32'h31, 32'h0000BEEF, 2'b01);
        2: ld(0, 32'h30);
        3: ld(1, 32'h4000);
        4: begin st(1, 32'h34, 32'h55555555, 2'b11); st(0, 32'h32, 32'h66666666, 2'b10); end
        5: begin st(0, 32'h4000, 32'h00000012, 2'b00); ld(1, 32'h30); end
        6: ;
        default: begin st(0, 32'h30, 32'h00000012, 2'b11); ld(0, 32'h30); end
      endcase
      step();
      exp_r = sbq.pop_front();
      for (int s = 0; s < 2; s++) begin
        n_checks++; if (act_v[s] !== exp_r.v[s]) begin
          n_fail++; $display("[TB] FAIL errors k%0d p%0d rd_valid got %b exp %b", k, s, act_v[s], exp_r.v[s]); end
        n_checks++; if (act_d[s] !== exp_r.d[s]) begin
          n_fail++; $display("[TB] FAIL errors k%0d p%0d rd_data got %h exp %h", k, s, act_d[s], exp_r.d[s]); end
        n_checks++; if (act_e[s] !== exp_r.e[s]) begin
          n_fail++; $display("[TB] FAIL errors k%0d p%0d err got %b exp %b", k, s, act_e[s], exp_r.e[s]); end
      end
      if (k == 3) begin
        n_checks++; if (p1_rd_data !== 32'h0 || p1_rd_valid !== 1'b1 || p1_err !== 1'b1) begin
          n_fail++; $display("[TB] FAIL oor_load got %h/%b/%b exp 0/1/1", p1_rd_data, p1_rd_valid, p1_err); end
      end
      if (k == 7) begin
        n_checks++; if (p0_rd_data !== 32'h0BADF00D || p0_err !== 1'b1) begin
          n_fail++; $display("[TB] FAIL no_fwd_illegal got %h/%b exp 0badf00d/1", p0_rd_data, p0_err); end
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k < 7; k++) begin
      clear_inputs();
      case (k)
        0: ;
        1, 2, 3: begin stall = 1'b1; ld(0, 32'h10); st(1, 32'h10, 32'hFFFFFFFF, 2'b10); end
        4: ld(0, 32'h10);
        5: ;
        default: ld(1, 32'h10);
      endcase
      step();
      exp_r = sbq.pop_front();
      for (int s = 0; s < 2; s++) begin
        n_checks++; if (act_v[s] !== exp_r.v[s]) begin
          n_fail++; $display("[TB] FAIL stall k%0d p%0d rd_valid got %b exp %b", k, s, act_v[s], exp_r.v[s]); end
        n_checks++; if (act_d[s] !== exp_r.d[s]) begin
          n_fail++; $display("[TB] FAIL stall k%0d p%0d rd_data got %h exp %h", k, s, act_d[s], exp_r.d[s]); end
        n_checks++; if (act_e[s] !== exp_r.e[s]) begin
          n_fail++; $display("[TB] FAIL stall k%0d p%0d err got %b exp %b", k, s, act_e[s], exp_r.e[s]); end
      end
      if (k >= 1 && k <= 3) begin
        n_checks++; if (p0_rd_valid !== 1'b0) begin
          n_fail++; $display("[TB] FAIL stall_hold k%0d rd_valid got %b exp 0", k, p0_rd_valid); end
      end
      if (k == 4) begin
        n_checks++; if (p0_rd_data !== 32'hAA223344 || p0_rd_valid !== 1'b1) begin
          n_fail++; $display("[TB] FAIL stall_release got %h/%b exp aa223344/1", p0_rd_data, p0_rd_valid); end
      end
    end
  endtask

  task automatic test_async_reset();
    clear_inputs();
    ld(0, 32'h10);
    step();
    exp_r = sbq.pop_front();
    n_checks++; if (p0_rd_valid !== 1'b1 || p0_rd_data !== exp_r.d[0]) begin
      n_fail++; $display("[TB] FAIL pre_reset got %h/%b exp %h/1", p0_rd_data, p0_rd_valid, exp_r.d[0]); end
    st(0, 32'h10, 32'h55555555, 2'b10);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (p0_rd_valid !== 1'b0 || p0_rd_data !== 32'h0 || p0_err !== 1'b0) begin
      n_fail++; $display("[TB] FAIL async_reset got %h/%b/%b exp 0/0/0", p0_rd_data, p0_rd_valid, p0_err); end
    @(posedge clk);
    #1;
    n_checks++; if (p0_rd_valid !== 1'b0 || p0_rd_data !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_held got %h/%b exp 0/0", p0_rd_data, p0_rd_valid); end
    rst = 1'b0;
    mod_d = '0; mod_v = '0; mod_err = '0;
    clear_inputs();
    ld(0, 32'h10);
    step();
    exp_r = sbq.pop_front();
    n_checks++; if (p0_rd_data !== exp_r.d[0] || p0_rd_data !== 32'hAA223344 || p0_rd_valid !== 1'b1) begin
      n_fail++; $display("[TB] FAIL reset_no_commit got %h/%b exp aa223344/1", p0_rd_data, p0_rd_valid); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 48; k++) begin
      clear_inputs();
      if (k < 8) begin
        st(0, 32'h100 + 32'(8 * k), $urandom, 2'b10);
        st(1, 32'h104 + 32'(8 * k), $urandom, 2'b10);
      end else begin
        if ($urandom_range(0, 3) != 0) st(0, 32'h100 + 32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)));
        if ($urandom_range(0, 3) != 0) st(1, 32'h100 + 32'($urandom_range(0, 63)), $urandom, 2'($urandom_range(0, 3)));
        for (int s = 0; s < 2; s++) begin
          if ($urandom_range(0, 4) != 0)
            ld(s, ($urandom_range(0, 7) == 0) ? 32'h4000 + 32'($urandom_range(0, 255))
                                              : 32'h100 + 32'($urandom_range(0, 63)));
        end
        stall = ($urandom_range(0, 7) == 0);
      end
      step();
      exp_r = sbq.pop_front();
      for (int s = 0; s < 2; s++) begin
        n_checks++; if (act_v[s] !== exp_r.v[s]) begin
          n_fail++; $display("[TB] FAIL b2b k%0d p%0d rd_valid got %b exp %b", k, s, act_v[s], exp_r.v[s]); end
        n_checks++; if (act_d[s] !== exp_r.d[s]) begin
          n_fail++; $display("[TB] FAIL b2b k%0d p%0d rd_data got %h exp %h", k, s, act_d[s], exp_r.d[s]); end
        n_checks++; if (act_e[s] !== exp_r.e[s]) begin
          n_fail++; $display("[TB] FAIL b2b k%0d p%0d err got %b exp %b", k, s, act_e[s], exp_r.e[s]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_merge();
    test_errors();
    test_stall();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
